// File: rtl/ad100_lsu_if.sv
// Request/response and memory-port-2 signals of the ad100 load/store unit.
// master = pipeline/memory side, slave = the LSU itself.
interface ad100_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [29:0] addr_2;
    logic [31:0] read_2;
    logic [31:0] write_2;
    logic        write_enable_1;
    logic        write_enable_2;
    logic        write_enable_3;
    logic        write_enable_4;

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, read_2,
        input  req_ready, resp_valid, resp_rdata, resp_error, addr_2, write_2,
        input  write_enable_1, write_enable_2, write_enable_3, write_enable_4
    );

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, read_2,
        output req_ready, resp_valid, resp_rdata, resp_error, addr_2, write_2,
        output write_enable_1, write_enable_2, write_enable_3, write_enable_4
    );
endinterface

// File: rtl/ad100_lsu.sv
// Load/store initiator for memory port 2: lane steering, sizing, extension.
// Define AD100_LSU_MISALIGN_EN to split word-crossing accesses in two.
module ad100_lsu (
    input  logic       clk,
    input  logic       rst,
    ad100_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    state_t      state, state_nx;
    logic        store_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q;

    // Requests rejected at accept time never touch memory.
    logic req_bad;
`ifdef AD100_LSU_MISALIGN_EN
    assign req_bad = (bus.req_size == 2'b11);
`else
    logic [7:0] lanes_in;
    assign lanes_in = {4'b0000, size_mask(bus.req_size)} << bus.req_addr[1:0];
    assign req_bad  = (bus.req_size == 2'b11) || (lanes_in[7:4] != 4'b0000) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]);
`endif

    logic [7:0]  lanes8;
    logic [31:0] wdata_sized, rd32, load_data;
    logic [63:0] data64;

    always_comb begin
        case (size_q)
            2'b00:   wdata_sized = {24'h0, wdata_q[7:0]};
            2'b01:   wdata_sized = {16'h0, wdata_q[15:0]};
            default: wdata_sized = wdata_q;
        endcase
    end

    assign lanes8 = {4'b0000, size_mask(size_q)} << addr_q[1:0];
    assign data64 = {32'h0, wdata_sized} << {addr_q[1:0], 3'b000};
    assign rd32   = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

`ifndef AD100_LSU_MISALIGN_EN
    logic unused_split;
    assign unused_split = ^{lanes8[7:4], data64[63:32]};
`endif

    always_comb begin
        case (size_q)
            2'b00:   load_data = signed_q ? {{24{rd32[7]}}, rd32[7:0]}
                                          : {24'h0, rd32[7:0]};
            2'b01:   load_data = signed_q ? {{16{rd32[15]}}, rd32[15:0]}
                                          : {16'h0, rd32[15:0]};
            default: load_data = rd32;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            lo_q     <= 32'h0;
            hi_q     <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req_valid) begin
                store_q  <= bus.req_store;
                signed_q <= bus.req_signed;
                size_q   <= bus.req_size;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                err_q    <= req_bad;
                hi_q     <= 32'h0;
            end
            if (state == ACC1 && !store_q) lo_q <= bus.read_2;
`ifdef AD100_LSU_MISALIGN_EN
            if (state == ACC2 && !store_q) hi_q <= bus.read_2;
`endif
        end
    end

    logic        req_ready_c, resp_valid_c, resp_error_c;
    logic [31:0] resp_rdata_c, write_c;
    logic [29:0] addr_c;
    logic [3:0]  en_c;

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nx     = state;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        resp_error_c = 1'b0;
        resp_rdata_c = 32'h0;
        addr_c       = 30'h0;
        write_c      = 32'h0;
        en_c         = 4'b0000;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_nx = req_bad ? DONE : ACC1;
            end
            ACC1: begin
                addr_c = addr_q[31:2];
                if (store_q) begin
                    write_c = data64[31:0];
                    en_c    = lanes8[3:0];
                end
`ifdef AD100_LSU_MISALIGN_EN
                state_nx = (lanes8[7:4] != 4'b0000) ? ACC2 : DONE;
`else
                state_nx = DONE;
`endif
            end
`ifdef AD100_LSU_MISALIGN_EN
            ACC2: begin
                // Word address wraps from 0x3FFFFFFF to 0 by plain overflow.
                addr_c = addr_q[31:2] + 30'd1;
                if (store_q) begin
                    write_c = data64[63:32];
                    en_c    = lanes8[7:4];
                end
                state_nx = DONE;
            end
`endif
            DONE: begin
                resp_valid_c = 1'b1;
                resp_error_c = err_q;
                if (!store_q && !err_q) resp_rdata_c = load_data;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready      = req_ready_c;
    assign bus.resp_valid     = resp_valid_c;
    assign bus.resp_error     = resp_error_c;
    assign bus.resp_rdata     = resp_rdata_c;
    assign bus.addr_2         = addr_c;
    assign bus.write_2        = write_c;
    assign bus.write_enable_1 = en_c[0];
    assign bus.write_enable_2 = en_c[1];
    assign bus.write_enable_3 = en_c[2];
    assign bus.write_enable_4 = en_c[3];
endmodule
